// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt acknowledge path.
// Contents: the controller state enum, the source count, the vector stride,
// the drain length and the per-source vector offsets. pr_enc uses the same
// offsets, so both sides agree on the vector map.
package intr_pkg;

    localparam int NSRC       = 4;
    localparam int SRC_W      = 2;
    localparam int VEC_STRIDE = 4;
    localparam int DRAIN_CYC  = 2;
    localparam int DRAIN_W    = 1;

    // The drain counter counts down to zero, so it is loaded with one less
    // than the number of holdoff cycles.
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);

    // Offset of each source's vector from VEC_BASE.
    localparam logic [31:0] VEC_OFS [NSRC] = '{32'h0, 32'h4, 32'h8, 32'hC};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_SERVICE,
        ST_ACK,
        ST_DRAIN
    } intr_state_t;

endpackage

// File: rtl/intr_vec_dec.sv
// Combinational vector decoder. It maps an encoder vector address to a
// validity flag, a source index and a one-hot source select.
//   eaddr  : vector address from pr_enc
//   valid  : address lies in the VEC_BASE window and is word aligned
//   src    : source index, taken from eaddr[3:2]
//   onehot : 1 << src
module intr_vec_dec
    import intr_pkg::*;
#(
    parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
    input  logic [31:0]      eaddr,
    output logic             valid,
    output logic [SRC_W-1:0] src,
    output logic [NSRC-1:0]  onehot
);

    always_comb begin
        valid       = (eaddr[31:4] == VEC_BASE[31:4]) && (eaddr[1:0] == 2'b00);
        src         = eaddr[3:2];
        onehot      = '0;
        onehot[src] = 1'b1;
    end

endmodule

// File: rtl/intr_ack_dec.sv
// Interrupt acknowledge/decode, CPU side of pr_enc.
// The block captures the irq/EAddr pair and presents one interrupt at a time
// to the CPU. It tracks the take/eret handshake. On return it sends a one-hot
// pulse to clear the originating accelerator's done flag.
//   clk, rst   : clock; synchronous active-high reset
//   irq_in     : request from pr_enc
//   eaddr_in   : vector from pr_enc (meaningful while irq_in=1)
//   int_en     : CPU global interrupt enable
//   take       : CPU accepts the interrupt (pulse)
//   eret       : handler return (pulse)
//   irq_cpu    : interrupt request to the CPU
//   vec_addr   : captured vector, held until the next capture
//   in_service : handler running
//   ack        : one-hot, one-cycle done-clear pulse
//   bad_vec    : sticky, an invalid vector was seen
//   svc_cnt    : completed services, wraps
module intr_ack_dec
    import intr_pkg::*;
#(
    parameter logic [31:0] VEC_BASE = 32'h0000_0000,
    parameter int          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             irq_in,
    input  logic [31:0]      eaddr_in,
    input  logic             int_en,
    input  logic             take,
    input  logic             eret,
    output logic             irq_cpu,
    output logic [31:0]      vec_addr,
    output logic             in_service,
    output logic [NSRC-1:0]  ack,
    output logic             bad_vec,
    output logic [CNT_W-1:0] svc_cnt
);

    intr_state_t        state, state_nx;
    logic [SRC_W-1:0]   src_q;
    logic [DRAIN_W-1:0] drain_cnt, drain_nx;
    logic               cap, bad_seen;

    logic               dec_valid;
    logic [SRC_W-1:0]   dec_src;
    logic [NSRC-1:0]    dec_oh;

    intr_vec_dec #(.VEC_BASE(VEC_BASE)) u_dec (
        .eaddr  (eaddr_in),
        .valid  (dec_valid),
        .src    (dec_src),
        .onehot (dec_oh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            vec_addr  <= '0;
            src_q     <= '0;
            bad_vec   <= 1'b0;
            svc_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_nx;
            if (cap) begin
                vec_addr <= eaddr_in;
                src_q    <= dec_src;
            end
            if (bad_seen)
                bad_vec <= 1'b1;
            if (state == ST_ACK)
                svc_cnt <= svc_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        drain_nx = drain_cnt;
        cap      = 1'b0;
        bad_seen = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // With int_en low the request is left pending at the encoder.
                if (irq_in && int_en) begin
                    if (dec_valid) begin
                        cap      = 1'b1;
                        state_nx = ST_PEND;
                    end else begin
                        bad_seen = 1'b1;
                    end
                end
            end
            ST_PEND: begin
                // take counts only while irq_cpu is visible to the CPU.
                if (take && int_en)
                    state_nx = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (eret)
                    state_nx = ST_ACK;
            end
            ST_ACK: begin
                drain_nx = DRAIN_LOAD;
                state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The holdoff gives the source time to clear done and gives
                // pr_enc time to update its registered output. Without it, a
                // stale irq_in would be recaptured.
                if (drain_cnt == '0)
                    state_nx = ST_IDLE;
                else
                    drain_nx = drain_cnt - 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state register, so they reset cleanly.
    always_comb begin
        irq_cpu    = (state == ST_PEND) && int_en;
        in_service = (state == ST_SERVICE);
        ack        = '0;
        if (state == ST_ACK)
            ack[src_q] = 1'b1;
    end

    // dec_oh is for decoder users; the ack pulse uses the latched index.
    logic unused_ok;
    assign unused_ok = ^dec_oh;

endmodule

// File: tb/tb_intr_ack_dec.sv
// Directed bench for intr_ack_dec. The stimulus pushes the expected ack and
// the pre-increment svc_cnt into a queue. A negedge monitor pops an entry and
// compares it whenever ack is nonzero.
module tb_intr_ack_dec;
    import intr_pkg::*;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, irq_in, int_en, take, eret;
    logic [31:0] eaddr_in;
    logic        irq_cpu, in_service, bad_vec;
    logic [31:0] vec_addr;
    logic [3:0]  ack;
    logic [7:0]  svc_cnt;

    logic [31:0]      sb_addr;
    logic             sb_valid;
    logic [SRC_W-1:0] sb_src;
    logic [NSRC-1:0]  sb_oh;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   last_ack_cyc = 0;
    bit   have_last = 1'b0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    intr_ack_dec #(.VEC_BASE(32'h0), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .eaddr_in   (eaddr_in),
        .int_en     (int_en),
        .take       (take),
        .eret       (eret),
        .irq_cpu    (irq_cpu),
        .vec_addr   (vec_addr),
        .in_service (in_service),
        .ack        (ack),
        .bad_vec    (bad_vec),
        .svc_cnt    (svc_cnt)
    );

    intr_vec_dec #(.VEC_BASE(32'h0)) u_sb_dec (
        .eaddr  (sb_addr),
        .valid  (sb_valid),
        .src    (sb_src),
        .onehot (sb_oh)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs take then eret from PEND. On return the DUT is in IDLE (cycle M+4).
    task automatic service(input logic [3:0] eack, input logic [7:0] cnt_before, input logic both);
        take = 1'b1;
        step();
        take = 1'b0;
        chk("take_irq_cpu", {31'b0, irq_cpu}, 32'h0);
        chk("take_in_service", {31'b0, in_service}, 32'h1);
        q.push_back('{ack: eack, cnt: cnt_before});
        eret = 1'b1;
        take = both;
        step();                                   // ACK cycle
        eret = 1'b0;
        take = 1'b0;
        chk("ack_cycle_in_service", {31'b0, in_service}, 32'h0);
        step();                                   // first DRAIN cycle
        chk("svc_cnt", {24'b0, svc_cnt}, {24'b0, cnt_before + 8'd1});
        step();                                   // second DRAIN cycle
        step();                                   // IDLE
    endtask

    // Scoreboard monitor: every nonzero ack must match the next queued entry.
    always @(negedge clk) begin
        if (ack !== 4'b0000) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ack: got %b, required no pulse", ack);
            end else begin
                mon_e = q.pop_front();
                if (ack !== mon_e.ack || svc_cnt !== mon_e.cnt) begin
                    n_bad++;
                    $display("FAIL ack_pulse: got ack=%b cnt=%0d, required ack=%b cnt=%0d",
                             ack, svc_cnt, mon_e.ack, mon_e.cnt);
                end
                if (have_last) begin
                    n_cmp++;
                    if (cyc - last_ack_cyc < 4) begin
                        n_bad++;
                        $display("FAIL ack_spacing: got %0d cycles, required >= 4", cyc - last_ack_cyc);
                    end
                end
                last_ack_cyc = cyc;
                have_last    = 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b1; irq_in = 1'b0; int_en = 1'b0; take = 1'b0; eret = 1'b0;
        eaddr_in = 32'h0; sb_addr = 32'h0;

        // Decoder checks, hand computed.
        sb_addr = 32'h8; #1;
        chk("dec8_valid", {31'b0, sb_valid}, 32'h1);
        chk("dec8_oh", {28'b0, sb_oh}, 32'h4);
        sb_addr = 32'h6; #1;
        chk("dec6_valid", {31'b0, sb_valid}, 32'h0);
        sb_addr = 32'h10; #1;
        chk("dec10_valid", {31'b0, sb_valid}, 32'h0);

        step(); step();
        chk("rst_irq_cpu", {31'b0, irq_cpu}, 32'h0);
        chk("rst_vec_addr", vec_addr, 32'h0);
        chk("rst_in_service", {31'b0, in_service}, 32'h0);
        chk("rst_ack", {28'b0, ack}, 32'h0);
        chk("rst_bad_vec", {31'b0, bad_vec}, 32'h0);
        chk("rst_svc_cnt", {24'b0, svc_cnt}, 32'h0);
        rst = 1'b0;

        // Single source 2.
        irq_in = 1'b1; eaddr_in = 32'h8; int_en = 1'b1;
        step();
        irq_in = 1'b0;
        chk("t1_irq_cpu", {31'b0, irq_cpu}, 32'h1);
        chk("t1_vec_addr", vec_addr, 32'h8);
        service(4'b0100, 8'd0, 1'b0);

        // Masked capture.
        int_en = 1'b0; irq_in = 1'b1; eaddr_in = 32'h0;
        step(); step();
        chk("mask_irq_cpu", {31'b0, irq_cpu}, 32'h0);
        chk("mask_no_capture", vec_addr, 32'h8);
        int_en = 1'b1;
        step();
        irq_in = 1'b0;
        chk("unmask_irq_cpu", {31'b0, irq_cpu}, 32'h1);
        chk("unmask_vec_addr", vec_addr, 32'h0);
        int_en = 1'b0; #1;
        chk("pend_drop_irq_cpu", {31'b0, irq_cpu}, 32'h0);
        take = 1'b1;
        step();
        take = 1'b0;
        chk("masked_take_ignored", {31'b0, in_service}, 32'h0);
        int_en = 1'b1;
        step();
        chk("pend_restore_irq_cpu", {31'b0, irq_cpu}, 32'h1);
        chk("pend_restore_vec", vec_addr, 32'h0);
        service(4'b0001, 8'd1, 1'b0);

        // Stale request is held through both DRAIN cycles and then dropped.
        irq_in = 1'b1; eaddr_in = 32'hC;
        step();
        chk("stale_cap_vec", vec_addr, 32'hC);
        service(4'b1000, 8'd2, 1'b0);
        irq_in = 1'b0;
        step(); step();
        chk("stale_no_recapture", {31'b0, irq_cpu}, 32'h0);
        chk("stale_svc_cnt", {24'b0, svc_cnt}, 32'h3);

        // Invalid vectors.
        irq_in = 1'b1; eaddr_in = 32'h6;
        step();
        chk("bad6_flag", {31'b0, bad_vec}, 32'h1);
        chk("bad6_irq_cpu", {31'b0, irq_cpu}, 32'h0);
        eaddr_in = 32'h10;
        step();
        chk("bad10_irq_cpu", {31'b0, irq_cpu}, 32'h0);
        irq_in = 1'b0;
        step(); step();
        chk("bad_sticky", {31'b0, bad_vec}, 32'h1);
        chk("bad_vec_addr_kept", vec_addr, 32'hC);

        // take and eret together: eret wins.
        irq_in = 1'b1; eaddr_in = 32'hC;
        step();
        irq_in = 1'b0;
        service(4'b1000, 8'd3, 1'b1);

        // Sources 0 and 1, back to back.
        irq_in = 1'b1; eaddr_in = 32'h0;
        step();
        irq_in = 1'b0;
        service(4'b0001, 8'd4, 1'b0);
        irq_in = 1'b1; eaddr_in = 32'h4;
        step();
        irq_in = 1'b0;
        chk("b2b_vec_addr", vec_addr, 32'h4);
        service(4'b0010, 8'd5, 1'b0);

        // Reset while in SERVICE.
        irq_in = 1'b1; eaddr_in = 32'h4;
        step();
        irq_in = 1'b0;
        take = 1'b1;
        step();
        take = 1'b0;
        chk("pre_rst_in_service", {31'b0, in_service}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_service", {31'b0, in_service}, 32'h0);
        chk("mid_rst_irq_cpu", {31'b0, irq_cpu}, 32'h0);
        chk("mid_rst_vec_addr", vec_addr, 32'h0);
        chk("mid_rst_bad_vec", {31'b0, bad_vec}, 32'h0);
        chk("mid_rst_svc_cnt", {24'b0, svc_cnt}, 32'h0);
        eret = 1'b1;
        step();
        eret = 1'b0;
        step(); step();
        chk("post_rst_svc_cnt", {24'b0, svc_cnt}, 32'h0);
        chk("sb_drained", q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/intr_ack_dec.md
# intr_ack_dec

Interrupt acknowledge/decode block on the CPU side of `pr_enc`. It captures the encoder's `irq`/`EAddr` pair and presents one interrupt at a time to the CPU. It tracks the CPU's take/return handshake. On return it decodes the captured vector back into a one-hot acknowledge pulse that clears the originating accelerator's `done` flag. It sits between `pr_enc`, the CPU exception logic and the four accelerator done registers.

## Interface
- `VEC_BASE`, 32'h00000000: vector base; valid vectors are `VEC_BASE + {0,4,8,C}`.
- `CNT_W`, 8: width of the serviced-interrupt counter.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `irq_in`  in  1  interrupt request from `pr_enc`.
- `eaddr_in`  in  32  vector address from `pr_enc`; meaningful only while `irq_in`=1.
- `int_en`  in  1  CPU global interrupt enable.
- `take`  in  1  CPU accepts the interrupt at an instruction boundary (1-cycle pulse).
- `eret`  in  1  CPU handler return (1-cycle pulse).
- `irq_cpu`  out  1  interrupt request to the CPU.
- `vec_addr`  out  32  captured vector address, stable from capture until the next capture.
- `in_service`  out  1  handler running.
- `ack`  out  4  one-hot, 1-cycle clear pulse to source `done[i]`.
- `bad_vec`  out  1  sticky error: invalid vector seen with `irq_in`=1.
- `svc_cnt`  out  CNT_W  completed services, wraps modulo 2^CNT_W.

## Operation
- States:
  - IDLE: sample inputs.
  - PEND: interrupt captured, waiting for the CPU.
  - SERVICE: handler running.
  - ACK: acknowledge pulse.
  - DRAIN: 2-cycle holdoff.
- Vector validity: `eaddr_in[31:4]==VEC_BASE[31:4]` and `eaddr_in[1:0]==0`. Source index is `eaddr_in[3:2]`.
- IDLE:
  - `irq_in && int_en && valid`: latch `vec_addr`, latch src index, go to PEND.
  - `irq_in && int_en && !valid`: set `bad_vec`, stay in IDLE, capture nothing.
  - `irq_in` with `int_en`=0: ignored; the request stays pending at the encoder.
- PEND:
  - `irq_cpu = (state==PEND) && int_en`, decoded combinationally from the state register.
  - `take` is honored only in a cycle where `irq_cpu`=1; it moves to SERVICE.
  - `int_en` falling in PEND drops `irq_cpu` but keeps the capture. `irq_cpu` returns when `int_en` returns.
- SERVICE:
  - `in_service`=1. `irq_in` is ignored (no nesting).
  - `eret` moves to ACK. If `take` and `eret` arrive together, `eret` wins.
- ACK: lasts one cycle. `ack[src]`=1, `svc_cnt` increments, then go to DRAIN.
- DRAIN:
  - 2-cycle down-counter, then IDLE. It covers the source clearing `done` plus `pr_enc`'s registered update, so a stale `irq_in` is never recaptured.
- Ignored inputs: `take` outside PEND, and `eret` outside SERVICE.
- `bad_vec` is cleared only by `rst`.

## Timing
- Reset: state IDLE; `irq_cpu`=0, `vec_addr`=0, `in_service`=0, `ack`=0, `bad_vec`=0, `svc_cnt`=0.
- Reset mid-operation from any state returns to IDLE with all of the above values. No `ack` is emitted and `svc_cnt` is not incremented.
- Capture: `irq_in` sampled at edge N gives `vec_addr` valid and `irq_cpu`=1 from edge N (cycle N+1), if `int_en`=1.
- `take` at edge T: `irq_cpu`=0 and `in_service`=1 from cycle T+1.
- `eret` at edge M:
  - `ack` is high for cycle M+1 only, and `svc_cnt` updates at edge M+1.
  - DRAIN occupies cycles M+2 and M+3.
  - IDLE is entered at edge M+3, and `irq_in` is first re-sampled at edge M+4.
- Minimum request-to-request turnaround: 4 cycles after `eret`.

## Structure
- Shared package `intr_pkg`:
  - state enum;
  - `NSRC`=4 and `VEC_STRIDE`=4;
  - `DRAIN_CYC`=2;
  - per-source vector offsets, also used by `pr_enc`.
- Sub-module `intr_vec_dec`: combinational `eaddr` to {valid, src index, one-hot}. It is reused by the bench scoreboard.
- Target size: 150–250 lines RTL including the sub-module.

## Test plan
- Single source: `irq_in`=1, `eaddr_in`=32'h8, `int_en`=1.
  - `irq_cpu`=1 next cycle and `vec_addr`=32'h8.
  - `take`, then `eret`: `ack`=4'b0100 for exactly 1 cycle and `svc_cnt`=1.
- Masked: `int_en`=0 with `irq_in`=1, `eaddr_in`=0 gives no capture and `irq_cpu`=0.
  - Raising `int_en` captures with `vec_addr`=0.
  - Dropping `int_en` in PEND drops `irq_cpu`, and restoring it raises `irq_cpu` again with `vec_addr` unchanged.
- Stale request: hold `irq_in`=1, `eaddr_in`=32'hC for 2 cycles after the `ack`=4'b1000 cycle, then drop it. No second capture; `svc_cnt` increments by 1 only.
- Invalid vectors: `eaddr_in`=32'h6 or 32'h10 with `irq_in`=1 gives `bad_vec`=1 (sticky), state stays IDLE, and `ack` stays 0.
- Simultaneous and back-to-back:
  - `take` and `eret` together in SERVICE: `eret` wins.
  - Sources 0 then 1 back-to-back give `ack`=4'b0001 then 4'b0010, at least 4 cycles apart.
- Reset in SERVICE: `rst`=1 for 1 cycle gives all outputs at reset values, no `ack`, and `svc_cnt`=0.
